// File: rtl/frame_buffer_sched_pkg.sv
// Shared definitions for the camera/VGA double-buffer scheduler:
// state encodings, SDRAM address width and default geometry.
package frame_buffer_sched_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned PIX_W  = 19;
  localparam int unsigned CNT_W  = 8;

  localparam int unsigned        FRAME_WORDS_DEF = 307200;
  localparam logic [ADDR_W-1:0] BUF_STRIDE_DEF  = 24'h080000;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_ARM     = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_COMMIT  = 3'd4;

endpackage

// File: rtl/frame_buffer_sched_sat_counter.sv
// 8-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter
  import frame_buffer_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != {CNT_W{1'b1}}))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/frame_buffer_sched.sv
// Ping-pong frame buffer scheduler: steers camera writes into one SDRAM buffer
// while the display reads the other, swapping on display start-of-frame.
module frame_buffer_sched
  import frame_buffer_sched_pkg::*;
#(
  parameter int unsigned        FRAME_WORDS   = FRAME_WORDS_DEF,
  parameter logic [ADDR_W-1:0] BUF_STRIDE    = BUF_STRIDE_DEF,
  parameter int unsigned        SETTLE_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cam_ready,
  input  logic              cam_sof,
  input  logic              cam_eof,
  input  logic              pix_valid,
  input  logic              vga_sof,
  output logic              wr_enable,
  output logic [ADDR_W-1:0] wr_base,
  output logic              wr_load,
  output logic [ADDR_W-1:0] rd_base,
  output logic              rd_load,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [2:0]        state
);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [7:0]        r_settle_cnt;
  logic [PIX_W-1:0]  r_pix_cnt;
  logic              r_rd_buf;
  logic              r_pending;
  logic              r_wr_load;
  logic              r_rd_load;
  logic [ADDR_W-1:0] r_wr_base;
  logic [ADDR_W-1:0] r_rd_base;

  logic w_start;
  logic w_frame_full;
  logic w_commit_ok;
  logic w_commit_bad;
  logic w_pend_mid;
  logic w_swap;
  logic w_rd_buf_nxt;
  logic w_err_inc;
  logic w_drop_inc;

  // Commit is resolved before the swap, and the swap before the writer picks
  // its buffer, so the writer always lands opposite the buffer being displayed.
  always_comb begin
    w_frame_full = (32'(r_pix_cnt) == FRAME_WORDS);
    w_start      = enable && cam_sof && ((r_state == ST_ARM) || (r_state == ST_CAPTURE));
    w_commit_ok  = enable && (r_state == ST_COMMIT) && w_frame_full;
    w_commit_bad = enable && (r_state == ST_COMMIT) && !w_frame_full;
    w_pend_mid   = r_pending || w_commit_ok;
    w_swap       = vga_sof && w_pend_mid;
    w_rd_buf_nxt = r_rd_buf ^ w_swap;
    w_err_inc    = w_commit_bad || (enable && (r_state == ST_CAPTURE) && cam_sof);
    w_drop_inc   = w_start && w_pend_mid && !w_swap;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:
          if (cam_ready)
            w_state_nxt = (SETTLE_FRAMES == 0) ? ST_ARM : ST_SETTLE;
        ST_SETTLE:
          if (cam_eof && (32'(r_settle_cnt) == SETTLE_FRAMES - 1))
            w_state_nxt = ST_ARM;
        ST_ARM:
          if (cam_sof)
            w_state_nxt = ST_CAPTURE;
        ST_CAPTURE:
          if (cam_sof)
            w_state_nxt = ST_CAPTURE;
          else if (cam_eof)
            w_state_nxt = ST_COMMIT;
        ST_COMMIT:
          w_state_nxt = ST_ARM;
        default:
          w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_pix_cnt    <= '0;
      r_rd_buf     <= 1'b0;
      r_pending    <= 1'b0;
      r_wr_load    <= 1'b0;
      r_rd_load    <= 1'b0;
      r_wr_base    <= '0;
      r_rd_base    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_load <= w_start;
      r_rd_load <= w_swap;
      r_rd_buf  <= w_rd_buf_nxt;

      if (r_state != ST_SETTLE)
        r_settle_cnt <= '0;
      else if (cam_eof)
        r_settle_cnt <= r_settle_cnt + 1'b1;

      if (w_start)
        r_pix_cnt <= '0;
      else if ((r_state == ST_CAPTURE) && pix_valid && (r_pix_cnt != {PIX_W{1'b1}}))
        r_pix_cnt <= r_pix_cnt + 1'b1;

      if (w_swap || w_start)
        r_pending <= 1'b0;
      else
        r_pending <= w_pend_mid;

      if (w_start)
        r_wr_base <= w_rd_buf_nxt ? '0 : BUF_STRIDE;
      if (w_swap)
        r_rd_base <= w_rd_buf_nxt ? BUF_STRIDE : '0;
    end
  end

  sat_counter u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_drop_inc),
    .o_cnt (drop_cnt)
  );

  sat_counter u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_err_inc),
    .o_cnt (err_cnt)
  );

  // Decoded from state so an asynchronous reset drops it immediately.
  assign wr_enable = (r_state == ST_CAPTURE);
  assign wr_base   = r_wr_base;
  assign wr_load   = r_wr_load;
  assign rd_base   = r_rd_base;
  assign rd_load   = r_rd_load;
  assign state     = r_state;

endmodule

// File: tb/tb_frame_buffer_sched.sv
// Directed bench for frame_buffer_sched using a short 8-pixel frame.
module tb_frame_buffer_sched;

  localparam int unsigned FW     = 8;
  localparam logic [23:0] STRIDE = 24'h080000;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        cam_ready;
  logic        cam_sof;
  logic        cam_eof;
  logic        pix_valid;
  logic        vga_sof;
  logic        wr_enable;
  logic [23:0] wr_base;
  logic        wr_load;
  logic [23:0] rd_base;
  logic        rd_load;
  logic [7:0]  drop_cnt;
  logic [7:0]  err_cnt;
  logic [2:0]  state;

  int n_run  = 0;
  int n_fail = 0;

  frame_buffer_sched #(
    .FRAME_WORDS   (FW),
    .BUF_STRIDE    (STRIDE),
    .SETTLE_FRAMES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cam_ready (cam_ready),
    .cam_sof   (cam_sof),
    .cam_eof   (cam_eof),
    .pix_valid (pix_valid),
    .vga_sof   (vga_sof),
    .wr_enable (wr_enable),
    .wr_base   (wr_base),
    .wr_load   (wr_load),
    .rd_base   (rd_base),
    .rd_load   (rd_load),
    .drop_cnt  (drop_cnt),
    .err_cnt   (err_cnt),
    .state     (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bringup();
    rst_n = 1'b0; enable = 1'b1; cam_ready = 1'b1;
    cam_sof = 1'b0; cam_eof = 1'b0; pix_valid = 1'b0; vga_sof = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    cam_eof = 1'b1; tick(); cam_eof = 1'b0;
    cam_eof = 1'b1; tick(); cam_eof = 1'b0;
  endtask

  task automatic pixels(input int n);
    pix_valid = 1'b1;
    repeat (n) tick();
    pix_valid = 1'b0;
  endtask

  task automatic frame(input int n);
    cam_sof = 1'b1; tick(); cam_sof = 1'b0;
    pixels(n);
    cam_eof = 1'b1; tick(); cam_eof = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; cam_ready = 1'b0;
    cam_sof = 1'b0; cam_eof = 1'b0; pix_valid = 1'b0; vga_sof = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_wr_enable", 32'(wr_enable), 32'd0);
    chk("rst_wr_load", 32'(wr_load), 32'd0);
    chk("rst_rd_load", 32'(rd_load), 32'd0);
    chk("rst_wr_base", 32'(wr_base), 32'd0);
    chk("rst_rd_base", 32'(rd_base), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);

    // Full good frame, then display swap
    rst_n = 1'b1; enable = 1'b1; cam_ready = 1'b1;
    tick();
    chk("settle_entry", 32'(state), 32'd1);
    cam_eof = 1'b1; tick(); cam_eof = 1'b0;
    chk("settle_after_eof1", 32'(state), 32'd1);
    cam_eof = 1'b1; tick(); cam_eof = 1'b0;
    chk("arm_after_eof2", 32'(state), 32'd2);
    chk("arm_wr_enable", 32'(wr_enable), 32'd0);
    cam_sof = 1'b1; tick(); cam_sof = 1'b0;
    chk("cap_state", 32'(state), 32'd3);
    chk("cap_wr_enable", 32'(wr_enable), 32'd1);
    chk("cap_wr_load", 32'(wr_load), 32'd1);
    chk("cap_wr_base", 32'(wr_base), 32'(STRIDE));
    pixels(FW);
    chk("cap_wr_load_done", 32'(wr_load), 32'd0);
    cam_eof = 1'b1; tick(); cam_eof = 1'b0;
    chk("commit_state", 32'(state), 32'd4);
    tick();
    chk("rearm_state", 32'(state), 32'd2);
    chk("good_err", 32'(err_cnt), 32'd0);
    chk("good_no_rd_load_yet", 32'(rd_load), 32'd0);
    vga_sof = 1'b1; tick(); vga_sof = 1'b0;
    chk("swap_rd_load", 32'(rd_load), 32'd1);
    chk("swap_rd_base", 32'(rd_base), 32'(STRIDE));
    tick();
    chk("swap_rd_load_pulse", 32'(rd_load), 32'd0);
    vga_sof = 1'b1; tick(); vga_sof = 1'b0;
    chk("noswap_rd_load", 32'(rd_load), 32'd0);
    chk("noswap_rd_base", 32'(rd_base), 32'(STRIDE));

    // Short frame is malformed
    bringup();
    frame(FW - 1);
    chk("short_err", 32'(err_cnt), 32'd1);
    chk("short_state", 32'(state), 32'd2);
    vga_sof = 1'b1; tick(); vga_sof = 1'b0;
    chk("short_no_rd_load", 32'(rd_load), 32'd0);
    chk("short_rd_base", 32'(rd_base), 32'd0);

    // Overlong frame is malformed too
    frame(FW + 1);
    chk("long_err", 32'(err_cnt), 32'd2);

    // Two good frames without a display swap
    bringup();
    frame(FW);
    cam_sof = 1'b1; tick(); cam_sof = 1'b0;
    chk("drop_cnt", 32'(drop_cnt), 32'd1);
    chk("drop_wr_base", 32'(wr_base), 32'(STRIDE));
    pixels(FW);
    cam_eof = 1'b1; tick(); cam_eof = 1'b0;
    tick();
    chk("drop_err", 32'(err_cnt), 32'd0);
    vga_sof = 1'b1; tick(); vga_sof = 1'b0;
    chk("drop_rd_load", 32'(rd_load), 32'd1);
    chk("drop_rd_base", 32'(rd_base), 32'(STRIDE));

    // Display swap coincident with capture start
    bringup();
    frame(FW);
    vga_sof = 1'b1; cam_sof = 1'b1; tick(); vga_sof = 1'b0; cam_sof = 1'b0;
    chk("coinc_rd_base", 32'(rd_base), 32'(STRIDE));
    chk("coinc_rd_load", 32'(rd_load), 32'd1);
    chk("coinc_wr_base", 32'(wr_base), 32'd0);
    chk("coinc_wr_load", 32'(wr_load), 32'd1);
    chk("coinc_drop", 32'(drop_cnt), 32'd0);
    chk("coinc_state", 32'(state), 32'd3);

    // Missed eof: sof restarts capture and counts an error
    pixels(3);
    cam_sof = 1'b1; tick(); cam_sof = 1'b0;
    chk("restart_err", 32'(err_cnt), 32'd1);
    chk("restart_wr_load", 32'(wr_load), 32'd1);
    chk("restart_state", 32'(state), 32'd3);
    chk("restart_wr_base", 32'(wr_base), 32'd0);

    // Enable dropped mid-capture
    pixels(3);
    enable = 1'b0; tick();
    chk("dis_wr_enable", 32'(wr_enable), 32'd0);
    chk("dis_state", 32'(state), 32'd0);
    chk("dis_err", 32'(err_cnt), 32'd1);
    cam_eof = 1'b1; tick(); cam_eof = 1'b0;
    chk("dis_stays_idle", 32'(state), 32'd0);
    chk("dis_rd_base_kept", 32'(rd_base), 32'(STRIDE));

    // Commit coincident with display swap
    bringup();
    cam_sof = 1'b1; tick(); cam_sof = 1'b0;
    pixels(FW);
    cam_eof = 1'b1; tick(); cam_eof = 1'b0;
    vga_sof = 1'b1; tick(); vga_sof = 1'b0;
    chk("cmsw_rd_load", 32'(rd_load), 32'd1);
    chk("cmsw_rd_base", 32'(rd_base), 32'(STRIDE));
    cam_sof = 1'b1; tick(); cam_sof = 1'b0;
    chk("cmsw_drop", 32'(drop_cnt), 32'd0);
    chk("cmsw_wr_base", 32'(wr_base), 32'd0);

    // Asynchronous reset mid-capture
    pixels(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_enable", 32'(wr_enable), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_rd_base", 32'(rd_base), 32'd0);
    chk("arst_wr_load", 32'(wr_load), 32'd0);
    chk("arst_rd_load", 32'(rd_load), 32'd0);
    chk("arst_wr_base", 32'(wr_base), 32'd0);

    // Error counter saturation via repeated sof during capture
    bringup();
    cam_sof = 1'b1;
    repeat (300) tick();
    cam_sof = 1'b0;
    chk("sat_err", 32'(err_cnt), 32'hFF);
    chk("sat_drop", 32'(drop_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
